// File: rtl/niox_spy_bd.sv
`default_nettype none
// ============================================================================
// Module   : niox_spy_bd
// Function : Spy-register host bridge to a block device. Word FIFOs,
//            start/busy/ready sequencing, start timeout, sticky status.
// Revision : 1.0
// ============================================================================

module niox_spy_bd_fifo #(
  parameter int DW      = 16,
  parameter int FIFO_AW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [DW-1:0]      din,
  input  logic               pop,
  output logic [DW-1:0]      dout,
  output logic [FIFO_AW:0]   count,
  output logic               full,
  output logic               empty,
  output logic               dropped
);

  localparam int c_DEPTH = 1 << FIFO_AW;

  logic [DW-1:0]      r_mem [c_DEPTH];
  logic [FIFO_AW-1:0] r_wptr;
  logic [FIFO_AW-1:0] r_rptr;
  logic [FIFO_AW:0]   r_count;
  logic               w_push_ok;
  logic               w_pop_ok;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign full      = (r_count == (FIFO_AW+1)'(c_DEPTH));
  assign empty     = (r_count == '0);
  assign w_pop_ok  = pop && !empty;
  assign w_push_ok = push && (!full || w_pop_ok);
  assign dropped   = push && !w_push_ok;
  assign dout      = r_mem[r_rptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wptr] <= din;
  end

endmodule

module niox_spy_bd #(
  parameter int DW         = 16,
  parameter int AW         = 24,
  parameter int FIFO_AW    = 8,
  parameter int XFER_WORDS = 256,
  parameter int TIMEOUT    = 65535
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] spy_in,
  output logic [DW-1:0] spy_out,
  input  logic [3:0]    spy_reg,
  input  logic          spy_rd,
  input  logic          spy_wr,
  output logic [1:0]    bd_cmd,
  output logic          bd_start,
  input  logic          bd_bsy,
  input  logic          bd_rdy,
  input  logic          bd_err,
  output logic [AW-1:0] bd_addr,
  input  logic [DW-1:0] bd_data_in,
  output logic [DW-1:0] bd_data_out,
  output logic          bd_rd,
  output logic          bd_wr,
  input  logic          bd_iordy,
  input  logic [15:0]   bd_state
);

  localparam int c_DEPTH = 1 << FIFO_AW;
  localparam int c_WCW   = $clog2(XFER_WORDS + 1);
  localparam int c_TCW   = $clog2(TIMEOUT + 1);
  localparam logic [c_WCW-1:0]   c_XFER_WORDS = c_WCW'(XFER_WORDS);
  localparam logic [c_TCW-1:0]   c_TMO_LAST   = c_TCW'(TIMEOUT - 1);
  localparam logic [FIFO_AW:0]   c_RF_ROOM    = (FIFO_AW+1)'(c_DEPTH - 2);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_XFER  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]       r_cmd;
  logic [AW-1:0]    r_addr;
  logic             r_done;
  logic             r_err;
  logic             r_tmo;
  logic             r_ovf;
  logic [c_TCW-1:0] r_tmo_cnt;
  logic [c_WCW-1:0] r_words;
  logic [c_WCW-1:0] r_issued;
  logic             r_bd_rd;
  logic             r_rd_cap;
  logic             r_bd_wr;
  logic [DW-1:0]    r_bd_data_out;
  logic [DW-1:0]    r_spy_out;

  logic             w_idle;
  logic             w_ctrl_wr;
  logic             w_go;
  logic             w_clear;
  logic             w_data_wr;
  logic             w_data_rd;
  logic             w_tmo_hit;
  logic             w_xfer_ok;
  logic             w_rd_issue;
  logic             w_wr_issue;
  logic [15:0]      w_status;

  logic [DW-1:0]    w_rf_dout;
  logic [FIFO_AW:0] w_rf_count;
  logic             w_rf_full;
  logic             w_rf_empty;
  logic             w_rf_dropped;
  logic [DW-1:0]    w_wf_dout;
  logic [FIFO_AW:0] w_wf_count;
  logic             w_wf_full;
  logic             w_wf_empty;
  logic             w_wf_dropped;
  logic             w_unused_ok;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_ctrl_wr = spy_wr && (spy_reg == 4'd2);
  assign w_go      = w_ctrl_wr && spy_in[2] && w_idle;
  assign w_clear   = w_ctrl_wr && spy_in[7];
  assign w_data_wr = spy_wr && (spy_reg == 4'd1);
  assign w_data_rd = spy_rd && (spy_reg == 4'd1);

  // Word pulses only while the device is still busy and no error is pending,
  // so a leaving transition never launches a stray pulse.
  assign w_xfer_ok  = (r_state == ST_XFER) && !bd_err && bd_bsy && !r_cmd[1];
  assign w_rd_issue = w_xfer_ok && (r_cmd == 2'd0) && bd_rdy && bd_iordy && !r_bd_rd
                      && (w_rf_count <= c_RF_ROOM) && (r_issued < c_XFER_WORDS);
  assign w_wr_issue = w_xfer_ok && (r_cmd == 2'd1) && bd_rdy && bd_iordy && !r_bd_wr
                      && !w_wf_empty && (r_issued < c_XFER_WORDS);

  assign w_status = {bd_state[5:0], r_ovf, r_tmo, r_done, r_err, !w_idle,
                     bd_bsy, bd_rdy, bd_err, bd_iordy, 1'b0};

  niox_spy_bd_fifo #(.DW(DW), .FIFO_AW(FIFO_AW)) u_rd_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (w_clear),
    .push    (r_rd_cap),
    .din     (bd_data_in),
    .pop     (w_data_rd),
    .dout    (w_rf_dout),
    .count   (w_rf_count),
    .full    (w_rf_full),
    .empty   (w_rf_empty),
    .dropped (w_rf_dropped)
  );

  niox_spy_bd_fifo #(.DW(DW), .FIFO_AW(FIFO_AW)) u_wr_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (w_clear),
    .push    (w_data_wr),
    .din     (spy_in),
    .pop     (w_wr_issue),
    .dout    (w_wf_dout),
    .count   (w_wf_count),
    .full    (w_wf_full),
    .empty   (w_wf_empty),
    .dropped (w_wf_dropped)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_tmo_hit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_go) w_next = ST_START;
      end
      ST_START: begin
        if (bd_err) begin
          w_next = ST_ERR;
        end else if (bd_bsy) begin
          w_next = ST_XFER;
        end else if (r_tmo_cnt == c_TMO_LAST) begin
          w_next    = ST_ERR;
          w_tmo_hit = 1'b1;
        end
      end
      ST_XFER: begin
        if (bd_err) w_next = ST_ERR;
        else if (r_cmd[1] || (r_words == c_XFER_WORDS) || !bd_bsy) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      ST_ERR:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmd  <= '0;
      r_addr <= '0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
      r_tmo  <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      if (w_ctrl_wr && w_idle) r_cmd <= spy_in[1:0];
      if (spy_wr && (spy_reg == 4'd3) && w_idle) r_addr[15:0]    <= spy_in[15:0];
      if (spy_wr && (spy_reg == 4'd4) && w_idle) r_addr[AW-1:16] <= spy_in[AW-17:0];
      if (w_clear) begin
        r_done <= 1'b0;
        r_err  <= 1'b0;
        r_tmo  <= 1'b0;
        r_ovf  <= 1'b0;
      end else begin
        if (w_go) begin
          r_done <= 1'b0;
          r_err  <= 1'b0;
          r_tmo  <= 1'b0;
        end
        if (r_state == ST_DONE) r_done <= 1'b1;
        if (r_state == ST_ERR)  r_err  <= 1'b1;
        if (w_tmo_hit)          r_tmo  <= 1'b1;
        if (w_wf_dropped)       r_ovf  <= 1'b1;
      end
    end
  end

  // Read words count when captured (one cycle after the bd_rd pulse);
  // write words count on the bd_wr pulse itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt     <= '0;
      r_words       <= '0;
      r_issued      <= '0;
      r_bd_rd       <= 1'b0;
      r_rd_cap      <= 1'b0;
      r_bd_wr       <= 1'b0;
      r_bd_data_out <= '0;
    end else begin
      r_bd_rd  <= w_rd_issue;
      r_rd_cap <= r_bd_rd;
      r_bd_wr  <= w_wr_issue;
      if (w_wr_issue) r_bd_data_out <= w_wf_dout;
      if (w_go) begin
        r_tmo_cnt <= '0;
        r_words   <= '0;
        r_issued  <= '0;
      end else begin
        if (r_state == ST_START)       r_tmo_cnt <= r_tmo_cnt + 1'b1;
        if (w_rd_issue || w_wr_issue)  r_issued  <= r_issued + 1'b1;
        if (r_rd_cap || r_bd_wr)       r_words   <= r_words + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_spy_out <= '0;
    end else if (spy_rd) begin
      case (spy_reg)
        4'd0:    r_spy_out <= DW'(w_status);
        4'd1:    r_spy_out <= w_rf_empty ? '0 : w_rf_dout;
        4'd2:    r_spy_out <= DW'(r_cmd);
        4'd3:    r_spy_out <= DW'(r_addr[15:0]);
        4'd4:    r_spy_out <= DW'(r_addr[AW-1:16]);
        4'd5:    r_spy_out <= DW'(w_rf_count);
        4'd6:    r_spy_out <= DW'(w_wf_count);
        default: r_spy_out <= DW'(16'h1234);
      endcase
    end
  end

  assign spy_out     = r_spy_out;
  assign bd_cmd      = r_cmd;
  assign bd_addr     = r_addr;
  assign bd_start    = (r_state == ST_START);
  assign bd_rd       = r_bd_rd;
  assign bd_wr       = r_bd_wr;
  assign bd_data_out = r_bd_data_out;

  assign w_unused_ok = &{1'b0, bd_state[15:6], w_rf_full, w_rf_dropped, w_wf_full};

endmodule

`default_nettype wire

// File: tb/tb_niox_spy_bd.sv
`default_nettype none
// ============================================================================
// Module   : tb_niox_spy_bd
// Function : Directed self-checking bench for niox_spy_bd.
// Revision : 1.0
// ============================================================================

module tb_niox_spy_bd;

  localparam int DW         = 16;
  localparam int AW         = 24;
  localparam int FIFO_AW    = 8;
  localparam int XFER_WORDS = 256;
  localparam int TIMEOUT    = 300;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] spy_in;
  logic [DW-1:0] spy_out;
  logic [3:0]    spy_reg;
  logic          spy_rd;
  logic          spy_wr;
  logic [1:0]    bd_cmd;
  logic          bd_start;
  logic          bd_bsy;
  logic          bd_rdy;
  logic          bd_err;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data_in = '0;
  logic [DW-1:0] bd_data_out;
  logic          bd_rd;
  logic          bd_wr;
  logic          bd_iordy;
  logic [15:0]   bd_state;

  always #5 clk = ~clk;

  niox_spy_bd #(
    .DW(DW), .AW(AW), .FIFO_AW(FIFO_AW), .XFER_WORDS(XFER_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .spy_in(spy_in), .spy_out(spy_out), .spy_reg(spy_reg),
    .spy_rd(spy_rd), .spy_wr(spy_wr), .bd_cmd(bd_cmd), .bd_start(bd_start),
    .bd_bsy(bd_bsy), .bd_rdy(bd_rdy), .bd_err(bd_err), .bd_addr(bd_addr),
    .bd_data_in(bd_data_in), .bd_data_out(bd_data_out), .bd_rd(bd_rd), .bd_wr(bd_wr),
    .bd_iordy(bd_iordy), .bd_state(bd_state)
  );

  int n_chk = 0;
  int n_err = 0;
  int dev_idx = 0;
  int dev_base = 0;
  int wr_idx = 0;
  int start_cyc = 0;
  int gap_viol = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  logic [DW-1:0] wr_log [512];

  // Device model: answers each bd_rd with its index, logs every bd_wr word.
  always @(negedge clk) begin
    if (bd_rd) begin
      bd_data_in = DW'(dev_idx - dev_base);
      dev_idx++;
    end
    if (bd_wr) begin
      wr_log[wr_idx % 512] = bd_data_out;
      wr_idx++;
    end
    if (bd_start) start_cyc++;
    if ((bd_rd && prev_rd) || (bd_wr && prev_wr)) gap_viol++;
    prev_rd = bd_rd;
    prev_wr = bd_wr;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spy_write(input logic [3:0] r, input logic [DW-1:0] d);
    @(negedge clk);
    spy_reg = r;
    spy_in  = d;
    spy_wr  = 1'b1;
    @(negedge clk);
    spy_wr  = 1'b0;
  endtask

  task automatic spy_read(input logic [3:0] r, output logic [DW-1:0] d);
    @(negedge clk);
    spy_reg = r;
    spy_rd  = 1'b1;
    @(negedge clk);
    spy_rd  = 1'b0;
    d = spy_out;
  endtask

  task automatic wait_idle(input string tag);
    logic [DW-1:0] s;
    int n;
    n = 0;
    do begin
      spy_read(4'd0, s);
      n++;
    end while (s[5] && n < 4000);
    chk(tag, 32'(s[5]), 32'd0);
  endtask

  task automatic dev_start();
    int n;
    n = 0;
    while (!bd_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", 32'(bd_start), 32'd1);
    repeat (3) @(negedge clk);
    bd_bsy   = 1'b1;
    bd_rdy   = 1'b1;
    bd_iordy = 1'b1;
  endtask

  task automatic dev_idle();
    bd_bsy   = 1'b0;
    bd_rdy   = 1'b0;
    bd_iordy = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    int n, k, wr_base;
    reset = 1'b1; spy_in = '0; spy_reg = '0; spy_rd = 1'b0; spy_wr = 1'b0;
    bd_bsy = 1'b0; bd_rdy = 1'b0; bd_err = 1'b0; bd_iordy = 1'b0; bd_state = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    chk("rst_bd_outs", 32'({bd_start, bd_rd, bd_wr, bd_addr}), 32'd0);
    chk("rst_data_out", 32'(bd_data_out), 32'd0);
    spy_read(4'd0, d); chk("rst_reg0", 32'(d), 32'h0000);
    spy_read(4'd7, d); chk("rst_reg7", 32'(d), 32'h1234);
    spy_read(4'd15, d); chk("rst_reg15", 32'(d), 32'h1234);
    bd_state = 16'hFFD5;
    spy_read(4'd0, d); chk("reg0_bd_state", 32'(d), 32'h5400);
    bd_state = '0;

    // Read transfer of 256 words
    spy_write(4'd3, 16'h2345);
    spy_write(4'd4, 16'h0001);
    chk("bd_addr", 32'(bd_addr), 32'h012345);
    dev_base = dev_idx;
    spy_write(4'd2, 16'h0004);
    dev_start();
    wait_idle("rd_idle");
    dev_idle();
    chk("rd_pulses", 32'(dev_idx - dev_base), 32'd256);
    spy_read(4'd5, d); chk("rd_reg5_full", 32'(d), 32'd256);
    spy_read(4'd0, d); chk("rd_reg0_done", 32'(d), 32'h0080);
    spy_read(4'd2, d); chk("rd_reg2", 32'(d), 32'd0);
    spy_read(4'd3, d); chk("rd_reg3", 32'(d), 32'h2345);
    spy_read(4'd4, d); chk("rd_reg4", 32'(d), 32'h0001);
    for (int i = 0; i < 256; i++) begin
      spy_read(4'd1, d);
      chk("rd_data", 32'(d), 32'(i));
    end
    spy_read(4'd5, d); chk("rd_reg5_empty", 32'(d), 32'd0);
    spy_read(4'd1, d); chk("rd_empty_pop", 32'(d), 32'd0);

    // Write transfer of 256 words plus an overflowing push
    for (int i = 0; i < 256; i++) spy_write(4'd1, DW'(16'hA000 + i));
    spy_read(4'd6, d); chk("wr_reg6_full", 32'(d), 32'd256);
    spy_write(4'd1, 16'hBEEF);
    spy_read(4'd6, d); chk("wr_reg6_ovf", 32'(d), 32'd256);
    spy_read(4'd0, d); chk("wr_reg0_ovf", 32'(d), 32'h0280);
    wr_base = wr_idx;
    spy_write(4'd2, 16'h0005);
    chk("wr_bd_cmd", 32'(bd_cmd), 32'd1);
    dev_start();
    wait_idle("wr_idle");
    dev_idle();
    chk("wr_pulses", 32'(wr_idx - wr_base), 32'd256);
    for (int i = 0; i < 256; i++)
      chk("wr_data", 32'(wr_log[(wr_base + i) % 512]), 32'(16'hA000 + i));
    chk("wr_hold", 32'(bd_data_out), 32'hA0FF);
    spy_read(4'd6, d); chk("wr_reg6_empty", 32'(d), 32'd0);
    spy_read(4'd0, d); chk("wr_reg0_done", 32'(d), 32'h0280);
    spy_write(4'd2, 16'h0080);
    spy_read(4'd0, d); chk("clear_reg0", 32'(d), 32'h0000);

    // Start timeout: device never raises bsy
    n = start_cyc;
    spy_write(4'd2, 16'h0006);
    wait_idle("tmo_idle");
    chk("tmo_start_cycles", 32'(start_cyc - n), 32'(TIMEOUT));
    chk("tmo_bd_start", 32'(bd_start), 32'd0);
    chk("tmo_bd_cmd", 32'(bd_cmd), 32'd2);
    spy_read(4'd0, d); chk("tmo_reg0", 32'(d), 32'h0140);

    // Device error after 10 read words; a second go is ignored
    spy_write(4'd2, 16'h0080);
    dev_base = dev_idx;
    spy_write(4'd2, 16'h0004);
    dev_start();
    n = 0; k = 0;
    while (n < 10 && k < 200) begin
      @(negedge clk);
      if (bd_rd) n++;
      k++;
    end
    bd_rdy = 1'b0;
    chk("err_pulses_seen", 32'(n), 32'd10);
    spy_write(4'd2, 16'h0005);
    spy_read(4'd2, d); chk("err_go_ignored", 32'(d), 32'd0);
    spy_read(4'd0, d); chk("err_busy", 32'(d), 32'h0032);
    @(negedge clk); bd_err = 1'b1;
    @(negedge clk); bd_err = 1'b0;
    wait_idle("err_idle");
    dev_idle();
    spy_read(4'd0, d); chk("err_reg0", 32'(d), 32'h0040);
    spy_read(4'd5, d); chk("err_reg5", 32'(d), 32'd10);
    chk("err_pulses", 32'(dev_idx - dev_base), 32'd10);

    // Reset in the middle of a read transfer
    spy_write(4'd2, 16'h0080);
    spy_write(4'd2, 16'h0004);
    dev_start();
    n = 0; k = 0;
    while (n < 5 && k < 200) begin
      @(negedge clk);
      if (bd_rd) n++;
      k++;
    end
    chk("rst_mid_pulse", 32'(bd_rd), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_drop", 32'({bd_start, bd_rd, bd_wr}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dev_idle();
    spy_read(4'd5, d); chk("rst_mid_reg5", 32'(d), 32'd0);
    spy_read(4'd0, d); chk("rst_mid_reg0", 32'(d), 32'h0000);

    chk("pulse_spacing", 32'(gap_viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not complete, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
